bch_encoder: RTL and testbench

//   Systematic binary BCH encoder (t=2), the transmit-side counterpart of the bch decoder.

---
 rtl/bch_encoder.sv | 192 +++++++++++++++++++
 tb/tb_bch_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bch_encoder.sv
// ---------------------------------------------------------------------------
// bch_encoder
//   Systematic binary BCH encoder (t=2) for BCH(63,51), BCH(255,239) and
//   BCH(1023,1003). The message arrives as 64-bit words, MSB-first. Parity is
//   accumulated by a 64-bit-parallel LFSR. The codeword leaves as 64-bit words
//   in the decoder's input format. The last word carries the message tail,
//   then the parity bits, then a single pad bit that is always 0.
//
// Ports
//   clk     in   1   clock, rising edge
//   rstn    in   1   asynchronous active-low reset
//   code    in   2   1:(63,51) 2:(255,239) 3:(1023,1003), sampled with set
//   set     in   1   one-cycle frame start pulse (honoured only in IDLE)
//   idata   in   64  message word, captured on every edge where ready==1
//   ready   out  1   encoder consumes one message word this cycle
//   ovalid  out  1   odata holds a valid codeword word
//   odata   out  64  codeword word, MSB-first
//   finish  out  1   high with ovalid on the last codeword word
// ---------------------------------------------------------------------------
module bch_encoder (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  code,
  input  logic        set,
  input  logic [63:0] idata,
  output logic        ready,
  output logic        ovalid,
  output logic [63:0] odata,
  output logic        finish
);

  // Generator polynomials, including the leading x^R term.
  localparam logic [12:0] G63   = 13'h1539;
  localparam logic [16:0] G255  = 17'h16F63;
  localparam logic [20:0] G1023 = 21'h101877;

  // The remainder is kept left-aligned in a 20-bit register, so the feedback
  // tap is always bit 19 whatever the degree. Generators are aligned the same way,
  // without their leading term.
  localparam logic [19:0] POLY63   = {G63[11:0], 8'h00};
  localparam logic [19:0] POLY255  = {G255[15:0], 4'h0};
  localparam logic [19:0] POLY1023 = G1023[19:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t      state_r;
  logic [1:0]  code_r;
  logic [3:0]  cnt_r;
  logic [19:0] rem_r;

  logic [3:0]  last_idx_s;
  logic [6:0]  msg_bits_s;
  logic [6:0]  nbits_s;
  logic [4:0]  par_shift_s;
  logic [19:0] poly_s;
  logic [63:0] msg_mask_s;
  logic        is_last_s;
  logic [19:0] rem_next_s;
  logic [19:0] parity_s;
  logic [63:0] last_word_s;

  // Bit-serial polynomial division, unrolled over one word. It consumes the top
  // nbits of data, MSB first, and computes rem*x^b + msg*x^R mod g.
  function automatic logic [19:0] lfsr_word(input logic [19:0] rem,
                                            input logic [63:0] data,
                                            input logic [6:0]  nbits,
                                            input logic [19:0] poly);
    logic [19:0] r;
    logic        fb;
    r = rem;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) < nbits) begin
        fb = r[19] ^ data[63 - i];
        r  = {r[18:0], 1'b0};
        if (fb) begin
          r = r ^ poly;
        end else begin
          r = r;
        end
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Per-code geometry: frame length, message bits in the last word, generator.
  always_comb begin
    last_idx_s  = 4'd0;
    msg_bits_s  = 7'd51;
    par_shift_s = 5'd8;
    poly_s      = POLY63;
    msg_mask_s  = 64'hFFFF_FFFF_FFFF_E000;
    case (code_r)
      2'd1: begin
        last_idx_s  = 4'd0;
        msg_bits_s  = 7'd51;
        par_shift_s = 5'd8;
        poly_s      = POLY63;
        msg_mask_s  = 64'hFFFF_FFFF_FFFF_E000;
      end
      2'd2: begin
        last_idx_s  = 4'd3;
        msg_bits_s  = 7'd47;
        par_shift_s = 5'd4;
        poly_s      = POLY255;
        msg_mask_s  = 64'hFFFF_FFFF_FFFE_0000;
      end
      2'd3: begin
        last_idx_s  = 4'd15;
        msg_bits_s  = 7'd43;
        par_shift_s = 5'd0;
        poly_s      = POLY1023;
        msg_mask_s  = 64'hFFFF_FFFF_FFE0_0000;
      end
      default: begin
        last_idx_s  = 4'd0;
        msg_bits_s  = 7'd51;
        par_shift_s = 5'd8;
        poly_s      = POLY63;
        msg_mask_s  = 64'hFFFF_FFFF_FFFF_E000;
      end
    endcase
  end

  // Next remainder and last-word assembly. On the last word, only the
  // message-tail bits enter the LFSR. The low bits of the input are replaced
  // by the parity and the pad.
  always_comb begin
    is_last_s   = (cnt_r == last_idx_s);
    nbits_s     = is_last_s ? msg_bits_s : 7'd64;
    rem_next_s  = lfsr_word(rem_r, idata, nbits_s, poly_s);
    parity_s    = rem_next_s >> par_shift_s;
    last_word_s = (idata & msg_mask_s) | {43'h0, parity_s, 1'b0};
  end

  // Frame FSM with registered handshake and codeword outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      code_r  <= 2'd0;
      cnt_r   <= 4'd0;
      rem_r   <= 20'd0;
      ready   <= 1'b0;
      ovalid  <= 1'b0;
      finish  <= 1'b0;
      odata   <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ovalid <= 1'b0;
          finish <= 1'b0;
          if (set && (code != 2'd0)) begin
            state_r <= ST_LOAD;
            code_r  <= code;
            cnt_r   <= 4'd0;
            rem_r   <= 20'd0;
            ready   <= 1'b1;
          end else begin
            ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          // ready is high for the whole of LOAD, so every edge here consumes a word.
          ovalid <= 1'b1;
          rem_r  <= rem_next_s;
          cnt_r  <= cnt_r + 4'd1;
          if (is_last_s) begin
            odata   <= last_word_s;
            finish  <= 1'b1;
            ready   <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            odata  <= idata;
            finish <= 1'b0;
            ready  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready   <= 1'b0;
          ovalid  <= 1'b0;
          finish  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encoder.sv
// ---------------------------------------------------------------------------
// tb_bch_encoder
//   Directed and random frames for bch_encoder. Each expected word goes into a
//   queue when its input is driven. The queue is popped when ovalid is seen.
//   Random frames are checked against polynomial long division over the full
//   codeword.
// ---------------------------------------------------------------------------
module tb_bch_encoder;

  logic        clk;
  logic        rstn;
  logic [1:0]  code;
  logic        set;
  logic [63:0] idata;
  logic        ready;
  logic        ovalid;
  logic [63:0] odata;
  logic        finish;

  int vectors;
  int miscompares;
  logic [64:0] exp_q[$];
  logic [63:0] wbuf[16];

  bch_encoder dut (
    .clk    (clk),
    .rstn   (rstn),
    .code   (code),
    .set    (set),
    .idata  (idata),
    .ready  (ready),
    .ovalid (ovalid),
    .odata  (odata),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then check any codeword word on the outputs.
  task automatic tick();
    logic [64:0] e;
    @(negedge clk);
    if (ovalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ovalid", 64'(ovalid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("odata", odata, e[63:0]);
        chk("finish", 64'(finish), 64'(e[64]));
      end
    end
  endtask

  function automatic int words_of(input logic [1:0] c);
    return (c == 2'd1) ? 1 : (c == 2'd2) ? 4 : 16;
  endfunction

  // Reference: arrange the message as a polynomial and divide x^R*m(x) by g(x)
  // with schoolbook long division.
  function automatic logic [63:0] model_last(input logic [1:0] c, input logic [63:0] w[16]);
    logic [1023:0] v;
    logic [20:0]   g;
    logic [63:0]   res;
    int nw, r, n, p, d;
    nw = words_of(c);
    r  = (c == 2'd1) ? 12 : (c == 2'd2) ? 16 : 20;
    g  = (c == 2'd1) ? 21'h01539 : (c == 2'd2) ? 21'h16F63 : 21'h101877;
    n  = 64 * nw - 1;
    v  = '0;
    for (int j = 0; j < nw; j++) begin
      for (int b = 63; b >= 0; b--) begin
        p = 64 * j + 63 - b;
        d = n - 1 - p;
        if (d >= r) v[d] = w[j][b];
      end
    end
    for (int dd = n - 1; dd >= r; dd--) begin
      if (v[dd]) begin
        for (int k = 0; k <= r; k++) v[dd - r + k] = v[dd - r + k] ^ g[k];
      end
    end
    res = (w[nw - 1] >> (r + 1)) << (r + 1);
    for (int k = 0; k < r; k++) res[k + 1] = v[k];
    return res;
  endfunction

  // Drive one frame, starting from a falling edge. The task returns on the
  // falling edge where finish should be high. glitch>=0 pulses set (with a
  // different code) while that word is presented.
  task automatic run_frame(input logic [1:0] c, input logic [63:0] w[16],
                           input logic [63:0] exp_last, input int glitch);
    int nw;
    nw   = words_of(c);
    set  = 1'b1;
    code = c;
    tick();
    set  = 1'b0;
    code = 2'd0;
    for (int i = 0; i < nw; i++) begin
      set  = (i == glitch) ? 1'b1 : 1'b0;
      code = (i == glitch) ? 2'd1 : 2'd0;
      chk("ready_high", 64'(ready), 64'd1);
      idata = w[i];
      exp_q.push_back({(i == nw - 1), (i == nw - 1) ? exp_last : w[i]});
      tick();
    end
    set = 1'b0;
    chk("ready_low_after_frame", 64'(ready), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    set         = 1'b0;
    code        = 2'd0;
    idata       = 64'd0;
    foreach (wbuf[i]) wbuf[i] = 64'd0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_odata", odata, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // set with code 0 is ignored
    set  = 1'b1;
    code = 2'd0;
    tick();
    set  = 1'b0;
    chk("code0_ignored", 64'(ready), 64'd0);
    tick();

    // 1: code 1, all-zero message
    run_frame(2'd1, wbuf, 64'h0, -1);
    tick();

    // 2: code 1, message LSB set
    wbuf[0] = 64'h2000;
    run_frame(2'd1, wbuf, 64'h2A72, -1);
    tick();

    // 5: don't-care bits and pad of the last word are ignored
    wbuf[0] = 64'h1FFF;
    run_frame(2'd1, wbuf, 64'h0, -1);
    tick();

    // 3: code 2, message LSB in the last word
    wbuf[0] = 64'h0;
    wbuf[3] = 64'h20000;
    run_frame(2'd2, wbuf, 64'h2DEC6, -1);
    tick();

    // 4: code 3, message LSB in the last word; set mid-LOAD is ignored
    wbuf[3]  = 64'h0;
    wbuf[15] = 64'h200000;
    run_frame(2'd3, wbuf, 64'h2030EE, 1);
    tick();
    chk("no_restart_after_glitch", 64'(ready), 64'd0);

    // Back-to-back: the next set lands on the finish cycle
    wbuf[15] = 64'h0;
    wbuf[0]  = 64'hDEAD_BEEF_0123_4567;
    run_frame(2'd1, wbuf, model_last(2'd1, wbuf), -1);
    wbuf[1] = 64'h8000_0000_0000_0001;
    wbuf[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_frame(2'd2, wbuf, model_last(2'd2, wbuf), -1);
    tick();

    // Random frames per code, with a random mix of back-to-back and idle gaps
    for (int c = 1; c <= 3; c++) begin
      for (int f = 0; f < 150; f++) begin
        foreach (wbuf[i]) wbuf[i] = {$urandom, $urandom};
        run_frame(2'(c), wbuf, model_last(2'(c), wbuf), -1);
        if ($urandom_range(1, 0) == 1) tick();
      end
    end
    tick();

    // rstn pulsed mid-frame: outputs clear and nothing follows release
    set  = 1'b1;
    code = 2'd3;
    tick();
    set  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ready_high_pre_abort", 64'(ready), 64'd1);
      idata = 64'hA5A5_0000_0000_0000 | 64'(i);
      exp_q.push_back({1'b0, idata});
      tick();
    end
    #1 rstn = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd0);
    chk("abort_ovalid", 64'(ovalid), 64'd0);
    chk("abort_finish", 64'(finish), 64'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_ready", 64'(ready), 64'd0);
    end

    // Frame after abort still works
    foreach (wbuf[i]) wbuf[i] = {$urandom, $urandom};
    run_frame(2'd2, wbuf, model_last(2'd2, wbuf), -1);
    tick();
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
